// File: rtl/router_fifo_pkt.sv
// router_fifo_pkt: parametrised router output FIFO with packet tracking.
// Stores header-tagged words, follows the length field of the packet
// being read, and reports occupancy, almost-full and a registered
// output-valid.
// Optional build macro ROUTER_FIFO_ERR_EN adds sticky ovf_err / unf_err.
module router_fifo_pkt #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     soft_reset,
  input  logic                     write_enb,
  input  logic                     lfd_state,
  input  logic [WIDTH-1:0]         datain,
  input  logic                     read_enb,
  output logic [WIDTH-1:0]         dataout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     pkt_busy,
  output logic                     pkt_last
`ifdef ROUTER_FIFO_ERR_EN
  ,
  output logic                     ovf_err,
  output logic                     unf_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = WIDTH - 1;
  localparam logic [AW:0] AF_TH = (AW+1)'(DEPTH - AF_MARGIN);

  // bit WIDTH of each entry marks a header word
  logic [WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [RW-1:0]    rem;
  logic             lfd_q;
  logic             wr_acc, rd_acc;
  logic [WIDTH:0]   rd_word;
  logic [RW-1:0]    hdr_rem;

  assign full        = (occupancy == (AW+1)'(DEPTH));
  assign empty       = (occupancy == '0);
  assign almost_full = (occupancy >= AF_TH);
  assign pkt_busy    = (rem != '0);

  assign wr_acc  = write_enb & ~full;
  assign rd_acc  = read_enb & ~empty;
  assign rd_word = mem[rd_ptr];
  // payload words plus the trailing parity word
  assign hdr_rem = {1'b0, rd_word[WIDTH-1:2]} + RW'(1);

  // storage array; no reset needed, occupancy guards every read
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= {lfd_q, datain};
  end

  // pointers, occupancy, header-tag delay
  always_ff @(posedge clk) begin
    if (!resetn || soft_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      lfd_q     <= 1'b0;
    end else begin
      lfd_q <= lfd_state;
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   occupancy <= occupancy + (AW+1)'(1);
        2'b01:   occupancy <= occupancy - (AW+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // read data path and packet word counter
  always_ff @(posedge clk) begin
    if (!resetn || soft_reset) begin
      dataout    <= '0;
      dout_valid <= 1'b0;
      pkt_last   <= 1'b0;
      rem        <= '0;
    end else begin
      dout_valid <= rd_acc;
      pkt_last   <= 1'b0;
      if (rd_acc) begin
        dataout <= rd_word[WIDTH-1:0];
        if (rd_word[WIDTH]) begin
          rem <= hdr_rem;
        end else if (rem != '0) begin
          rem      <= rem - RW'(1);
          pkt_last <= (rem == RW'(1));
        end
      end
    end
  end

`ifdef ROUTER_FIFO_ERR_EN
  // sticky illegal-request flags
  always_ff @(posedge clk) begin
    if (!resetn || soft_reset) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (write_enb && full)  ovf_err <= 1'b1;
      if (read_enb  && empty) unf_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_router_fifo_pkt.sv
// tb_router_fifo_pkt: directed plus randomized stimulus against a
// queue-based packet FIFO model; a second small instance covers
// WIDTH=16, DEPTH=4.
module tb_router_fifo_pkt;

  localparam int D = 16;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // default instance
  logic       sr, we, lfd, re;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dvld, fl, em, af, busy, last;
  logic [4:0] occ;

  // WIDTH=16, DEPTH=4 instance
  logic        sr1, we1, lfd1, re1;
  logic [15:0] din1, dout1;
  logic        dvld1, fl1, em1, af1, busy1, last1;
  logic [2:0]  occ1;

`ifdef ROUTER_FIFO_ERR_EN
  logic ovf, unf, ovf1, unf1;
`endif

  router_fifo_pkt u0 (
    .clk(clk), .resetn(resetn), .soft_reset(sr), .write_enb(we),
    .lfd_state(lfd), .datain(din), .read_enb(re), .dataout(dout),
    .dout_valid(dvld), .full(fl), .empty(em), .almost_full(af),
    .occupancy(occ), .pkt_busy(busy), .pkt_last(last)
`ifdef ROUTER_FIFO_ERR_EN
    , .ovf_err(ovf), .unf_err(unf)
`endif
  );

  router_fifo_pkt #(.WIDTH(16), .DEPTH(4), .AF_MARGIN(2)) u1 (
    .clk(clk), .resetn(resetn), .soft_reset(sr1), .write_enb(we1),
    .lfd_state(lfd1), .datain(din1), .read_enb(re1), .dataout(dout1),
    .dout_valid(dvld1), .full(fl1), .empty(em1), .almost_full(af1),
    .occupancy(occ1), .pkt_busy(busy1), .pkt_last(last1)
`ifdef ROUTER_FIFO_ERR_EN
    , .ovf_err(ovf1), .unf_err(unf1)
`endif
  );

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [8:0] q[$];
  int         m_rem;
  logic [7:0] m_dout;
  logic       m_vld, m_last, m_lfd, m_ovf, m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_rem = 0; m_dout = 8'h00; m_vld = 1'b0; m_last = 1'b0;
    m_lfd = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".occ"},   32'(occ),  32'(q.size()));
    chk({ctx, ".empty"}, 32'(em),   32'(q.size() == 0));
    chk({ctx, ".full"},  32'(fl),   32'(q.size() == D));
    chk({ctx, ".af"},    32'(af),   32'(q.size() >= D - 2));
    chk({ctx, ".dout"},  32'(dout), 32'(m_dout));
    chk({ctx, ".dvld"},  32'(dvld), 32'(m_vld));
    chk({ctx, ".busy"},  32'(busy), 32'(m_rem != 0));
    chk({ctx, ".last"},  32'(last), 32'(m_last));
`ifdef ROUTER_FIFO_ERR_EN
    chk({ctx, ".ovf"},   32'(ovf),  32'(m_ovf));
    chk({ctx, ".unf"},   32'(unf),  32'(m_unf));
`endif
  endtask

  // one clock of the default instance: drive, advance model, compare
  task automatic step(input string ctx, input logic w, input logic r,
                      input logic l, input logic [7:0] d, input logic s);
    logic [8:0] wd;
    bit wa, ra;
    we = w; re = r; lfd = l; din = d; sr = s;
    @(posedge clk);
    if (s) begin
      model_clear();
    end else begin
      wa = w && (q.size() < D);
      ra = r && (q.size() > 0);
      if (w && q.size() == D) m_ovf = 1'b1;
      if (r && q.size() == 0) m_unf = 1'b1;
      m_last = 1'b0;
      m_vld  = ra;
      if (ra) begin
        wd = q.pop_front();
        m_dout = wd[7:0];
        if (wd[8]) m_rem = int'(wd[7:2]) + 1;
        else if (m_rem != 0) begin
          m_last = (m_rem == 1);
          m_rem--;
        end
      end
      if (wa) q.push_back({m_lfd, d});
      m_lfd = l;
    end
    #1;
    check_all(ctx);
  endtask

  initial begin
    resetn = 1'b0;
    {sr, we, lfd, re, din} = '0;
    {sr1, we1, lfd1, re1, din1} = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    check_all("reset");

    // one packet: header 0x0C (len 3), 3 payload, parity, then read 5
    step("pkt.lfd", 0, 0, 1, 8'h00, 0);
    step("pkt.hdr", 1, 0, 0, 8'h0C, 0);
    step("pkt.p0",  1, 0, 0, 8'hA1, 0);
    step("pkt.p1",  1, 0, 0, 8'hA2, 0);
    step("pkt.p2",  1, 0, 0, 8'hA3, 0);
    step("pkt.par", 1, 0, 0, 8'h5F, 0);
    step("pkt.r0",  0, 1, 0, 8'h00, 0);
    chk("pkt.hdr_out", 32'(dout), 32'h0C);
    step("pkt.r1",  0, 1, 0, 8'h00, 0);
    step("pkt.r2",  0, 1, 0, 8'h00, 0);
    step("pkt.r3",  0, 1, 0, 8'h00, 0);
    step("pkt.r4",  0, 1, 0, 8'h00, 0);
    chk("pkt.last_at_parity", 32'({last, dout}), 32'h15F);
    step("pkt.idle", 0, 0, 0, 8'h00, 0);
    chk("pkt.busy_drop", 32'(busy), 32'd0);

    // fill to full, overflow attempt, drain with wrap
    for (int i = 0; i < D; i++) step("fill", 1, 0, 0, 8'($urandom), 0);
    chk("fill.full", 32'(fl), 32'd1);
    step("ovf", 1, 0, 0, 8'hEE, 0);
    for (int i = 0; i < D; i++) step("drain", 0, 1, 0, 8'h00, 0);
    step("drain.idle", 0, 0, 0, 8'h00, 0);
    chk("drain.empty", 32'(em), 32'd1);
    step("unf", 0, 1, 0, 8'h00, 0);

    // simultaneous read/write when full, then at occupancy 5
    for (int i = 0; i < D; i++) step("fill2", 1, 0, 0, 8'($urandom), 0);
    step("rw_full", 1, 1, 0, 8'h77, 0);
    chk("rw_full.occ", 32'(occ), 32'd15);
    for (int i = 0; i < 10; i++) step("to5", 0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) step("rw5", 1, 1, 0, 8'($urandom), 0);
    chk("rw5.occ", 32'(occ), 32'd5);
    for (int i = 0; i < 6; i++) step("drain5", 0, 1, 0, 8'h00, 0);

    // soft reset mid-packet (rem=2, occupancy 6)
    step("sr.lfd", 0, 0, 1, 8'h00, 0);
    step("sr.hdr", 1, 0, 0, 8'h0C, 0);
    for (int i = 0; i < 8; i++) step("sr.wr", 1, 0, 0, 8'(i + 8'h30), 0);
    for (int i = 0; i < 3; i++) step("sr.rd", 0, 1, 0, 8'h00, 0);
    chk("sr.pre_occ", 32'(occ), 32'd6);
    step("sr.pulse", 0, 0, 0, 8'h00, 1);
    chk("sr.post", 32'({occ, em, busy, dout}), 32'({5'd0, 1'b1, 1'b0, 8'h00}));
    step("sr2.lfd", 0, 0, 1, 8'h00, 0);
    step("sr2.hdr", 1, 0, 0, 8'h04, 0);
    step("sr2.p",   1, 0, 0, 8'h91, 0);
    step("sr2.par", 1, 0, 0, 8'h92, 0);
    for (int i = 0; i < 4; i++) step("sr2.rd", 0, 1, 0, 8'h00, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 5),
           1'($urandom_range(0, 7) == 0), 8'($urandom), 1'($urandom_range(0, 59) == 0));

    // WIDTH=16, DEPTH=4 instance
    lfd1 = 1'b1;
    @(posedge clk); #1;
    lfd1 = 1'b0; we1 = 1'b1; din1 = 16'h0010;
    @(posedge clk); #1;
    din1 = 16'h1111;
    @(posedge clk); #1;
    chk("w16.occ2", 32'(occ1), 32'd2);
    chk("w16.af2",  32'({af1, fl1}), 32'b10);
    din1 = 16'h2222;
    @(posedge clk); #1;
    din1 = 16'h3333;
    @(posedge clk); #1;
    chk("w16.full", 32'({fl1, occ1}), 32'({1'b1, 3'd4}));
    din1 = 16'h4444;
    @(posedge clk); #1;
    chk("w16.ovf_occ", 32'(occ1), 32'd4);
    we1 = 1'b0; re1 = 1'b1;
    @(posedge clk); #1;
    chk("w16.hdr_rd", 32'({dvld1, busy1, dout1}), 32'({1'b1, 1'b1, 16'h0010}));
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("w16.busy_rem2", 32'({busy1, last1, dout1}), 32'({1'b1, 1'b0, 16'h3333}));
    chk("w16.empty", 32'(em1), 32'd1);
    re1 = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
